cdb_arbiter: RTL and testbench

Arbitrates the single completion (common data) bus between the ALU and the store/load buffer (SLB). Each source's finished results are queued in a small per-source FIFO. One result per cycle is granted round-robin and broadcast as a registered write to the reorder buffer, reservation station and SLB. The block ensures the ROB never sees two completions in the same cycle, and it drops all in-flight results on a ROB exception flush.

---
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter.sv | 154 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Completion-bus handshake bundle: ALU and SLB result inputs, their ready
// back-pressure, and the registered broadcast toward ROB/RS/SLB.
interface cdb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);
  logic                  alu_valid;
  logic [PC_WIDTH-1:0]   alu_pc;
  logic [DATA_WIDTH-1:0] alu_data;
  logic [PC_WIDTH-1:0]   alu_jpc;
  logic                  alu_ready;
  logic                  slb_valid;
  logic [PC_WIDTH-1:0]   slb_pc;
  logic [DATA_WIDTH-1:0] slb_data;
  logic                  slb_ready;
  logic                  cdb_valid;
  logic [PC_WIDTH-1:0]   cdb_pc;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic [PC_WIDTH-1:0]   cdb_jpc;
  logic                  cdb_src;

  modport master (
    output alu_valid, alu_pc, alu_data, alu_jpc, slb_valid, slb_pc, slb_data,
    input  alu_ready, slb_ready, cdb_valid, cdb_pc, cdb_data, cdb_jpc, cdb_src
  );

  modport slave (
    input  alu_valid, alu_pc, alu_data, alu_jpc, slb_valid, slb_pc, slb_data,
    output alu_ready, slb_ready, cdb_valid, cdb_pc, cdb_data, cdb_jpc, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs, round-robin grant between
// ALU and SLB, one registered broadcast per cycle, cleared on ROB flush.
module cdb_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_valid,
  input  logic [W-1:0] push_entry,
  output logic         ready,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push, do_pop;

  // Full refuses a push even if the same edge pops; ready depends on count only.
  assign ready  = (cnt_q != (AW+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign head   = mem_q[rptr_q];
  assign push   = push_valid && ready && !flush;
  assign do_pop = pop && !empty;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push)   wptr_d = wptr_q + AW'(1);
      if (do_pop) rptr_d = rptr_q + AW'(1);
      if (push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (!push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is never cleared; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_entry;
  end
endmodule

module cdb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int  EW      = 2 * PC_WIDTH + DATA_WIDTH;
  localparam logic SRC_SLB = 1'b1;

  logic [EW-1:0] alu_entry, slb_entry, alu_head, slb_head, win_head;
  logic          alu_empty, slb_empty, alu_ready, slb_ready;
  logic          gnt_any, gnt_slb, alu_pop, slb_pop;

  logic                  last_grant_q, last_grant_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [PC_WIDTH-1:0]   cdb_pc_q, cdb_pc_d;
  logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic [PC_WIDTH-1:0]   cdb_jpc_q, cdb_jpc_d;
  logic                  cdb_src_q, cdb_src_d;

  // Loads/stores carry no branch target, so next-PC is the fall-through.
  assign alu_entry = {bus.alu_pc, bus.alu_data, bus.alu_jpc};
  assign slb_entry = {bus.slb_pc, bus.slb_data, bus.slb_pc + PC_WIDTH'(4)};

  cdb_fifo #(.W(EW), .DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(bus.alu_valid), .push_entry(alu_entry), .ready(alu_ready),
    .pop(alu_pop), .empty(alu_empty), .head(alu_head)
  );

  cdb_fifo #(.W(EW), .DEPTH(DEPTH)) u_slb_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(bus.slb_valid), .push_entry(slb_entry), .ready(slb_ready),
    .pop(slb_pop), .empty(slb_empty), .head(slb_head)
  );

  // On a tie the source that did not win last time goes next.
  assign gnt_any  = !alu_empty || !slb_empty;
  assign gnt_slb  = (!alu_empty && !slb_empty) ? !last_grant_q : !slb_empty;
  assign alu_pop  = gnt_any && !gnt_slb;
  assign slb_pop  = gnt_any && gnt_slb;
  assign win_head = gnt_slb ? slb_head : alu_head;

  always_comb begin
    last_grant_d = last_grant_q;
    cdb_valid_d  = 1'b0;
    cdb_pc_d     = cdb_pc_q;
    cdb_data_d   = cdb_data_q;
    cdb_jpc_d    = cdb_jpc_q;
    cdb_src_d    = cdb_src_q;
    if (flush) begin
      last_grant_d = SRC_SLB;
    end else if (gnt_any) begin
      cdb_valid_d                        = 1'b1;
      {cdb_pc_d, cdb_data_d, cdb_jpc_d}  = win_head;
      cdb_src_d                          = gnt_slb;
      last_grant_d                       = gnt_slb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= SRC_SLB;
      cdb_valid_q  <= 1'b0;
      cdb_pc_q     <= '0;
      cdb_data_q   <= '0;
      cdb_jpc_q    <= '0;
      cdb_src_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_pc_q     <= cdb_pc_d;
      cdb_data_q   <= cdb_data_d;
      cdb_jpc_q    <= cdb_jpc_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.slb_ready = slb_ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_pc    = cdb_pc_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_jpc   = cdb_jpc_q;
  assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table plus streaming
// sequences for saturation, full FIFO, wrap-around and asynchronous reset.
module tb_cdb_arbiter;
  localparam int DW = 32, PW = 32, DEPTH = 2;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) bus ();
  cdb_arbiter #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic av; logic [31:0] apc, adata, ajpc;
    logic sv; logic [31:0] spc, sdata;
    logic fl;
    logic ev; logic [31:0] epc, edata, ejpc; logic esrc, ear, esr;
  } vec_t;

  typedef struct { logic [31:0] pc, data, jpc; } ent_t;

  function automatic vec_t mk(input logic av, input logic [31:0] apc, adata, ajpc,
                              input logic sv, input logic [31:0] spc, sdata,
                              input logic fl, input logic ev,
                              input logic [31:0] epc, edata, ejpc,
                              input logic esrc, ear, esr);
    vec_t v;
    v.av = av; v.apc = apc; v.adata = adata; v.ajpc = ajpc;
    v.sv = sv; v.spc = spc; v.sdata = sdata; v.fl = fl;
    v.ev = ev; v.epc = epc; v.edata = edata; v.ejpc = ejpc;
    v.esrc = esrc; v.ear = ear; v.esr = esr;
    return v;
  endfunction

  function automatic vec_t idle(input logic ev, input logic [31:0] epc, edata, ejpc,
                                input logic esrc, ear, esr);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, ev, epc, edata, ejpc, esrc, ear, esr);
  endfunction

  task automatic drive_idle();
    bus.alu_valid = 1'b0; bus.alu_pc = '0; bus.alu_data = '0; bus.alu_jpc = '0;
    bus.slb_valid = 1'b0; bus.slb_pc = '0; bus.slb_data = '0;
    flush = 1'b0;
  endtask

  task automatic do_flush(input string tag);
    @(negedge clk);
    drive_idle();
    flush = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_flush_valid"}, bus.cdb_valid, 0);
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Drives both sources with valid/ready handshakes and checks every broadcast
  // against per-source push-order scoreboards.
  task automatic stream(input int na, input int ns, input bit chk_alt,
                        input bit exp_full, input string tag);
    ent_t qa[$], qs[$], e;
    int ia = 0, is = 0, ra = 0, rs = 0, cyc = 0;
    bit acc_a, acc_s, prev_src = 0, have_prev = 0, saw_full = 0;
    while ((ra < na || rs < ns) && cyc < 300) begin
      @(negedge clk);
      bus.alu_valid = (ia < na);
      bus.alu_pc    = 32'h1000 + 32'(ia) * 4;
      bus.alu_data  = bus.alu_pc ^ 32'hA5A5_0000;
      bus.alu_jpc   = bus.alu_pc + 32'h10;
      bus.slb_valid = (is < ns);
      bus.slb_pc    = 32'h2000 + 32'(is) * 4;
      bus.slb_data  = bus.slb_pc ^ 32'h0000_5A5A;
      #1;
      acc_a = bus.alu_valid && bus.alu_ready;
      acc_s = bus.slb_valid && bus.slb_ready;
      if (!bus.slb_ready) saw_full = 1;
      if (acc_a) begin e.pc = bus.alu_pc; e.data = bus.alu_data; e.jpc = bus.alu_jpc; qa.push_back(e); ia++; end
      if (acc_s) begin e.pc = bus.slb_pc; e.data = bus.slb_data; e.jpc = bus.slb_pc + 4; qs.push_back(e); is++; end
      @(posedge clk); #1;
      if (bus.cdb_valid) begin
        if (bus.cdb_src == 1'b0) begin
          if (qa.size() == 0) chk({tag, "_extra_alu"}, 1, 0);
          else begin e = qa.pop_front(); ra++; end
        end else begin
          if (qs.size() == 0) chk({tag, "_extra_slb"}, 1, 0);
          else begin e = qs.pop_front(); rs++; end
        end
        chk({tag, "_pc"}, bus.cdb_pc, e.pc);
        chk({tag, "_data"}, bus.cdb_data, e.data);
        chk({tag, "_jpc"}, bus.cdb_jpc, e.jpc);
        if (chk_alt) begin
          if (have_prev) chk({tag, "_alternate"}, bus.cdb_src, !prev_src);
          else           chk({tag, "_first_src"}, bus.cdb_src, 0);
        end
        prev_src = bus.cdb_src; have_prev = 1;
      end
      cyc++;
    end
    chk({tag, "_alu_count"}, ra, na);
    chk({tag, "_slb_count"}, rs, ns);
    if (exp_full) chk({tag, "_slb_full_seen"}, saw_full, 1);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    chk({tag, "_no_tail"}, bus.cdb_valid, 0);
  endtask

  vec_t vecs[$];

  initial begin
    drive_idle();
    // A: reset, single ALU result; B: simultaneous; C: flush; D: wrap of pc+4; E: full refusal
    vecs.push_back(mk(1, 'h100, 'h55, 'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(idle(1, 'h100, 'h55, 'h104, 0, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 'h10, 'h11, 'h14, 1, 'h20, 'h22, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(idle(1, 'h10, 'h11, 'h14, 0, 1, 1));
    vecs.push_back(idle(1, 'h20, 'h22, 'h24, 1, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 'h200, 'h2a, 'h208, 1, 'h300, 'h3b, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 'h204, 'h2c, 'h20c, 0, 0, 0, 0, 1, 'h200, 'h2a, 'h208, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h40, 'h4d, 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 'h500, 'h5e, 'h504, 1, 'h600, 'h6f, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(idle(1, 'h500, 'h5e, 'h504, 0, 1, 1));
    vecs.push_back(idle(1, 'h600, 'h6f, 'h604, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'hFFFF_FFFC, 'h77, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(idle(1, 'hFFFF_FFFC, 'h77, 'h0, 1, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 'h700, 'h71, 'h704, 1, 'h800, 'h81, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h804, 'h82, 0, 1, 'h700, 'h71, 'h704, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h808, 'h83, 0, 1, 'h800, 'h81, 'h804, 1, 1, 1));
    vecs.push_back(idle(1, 'h804, 'h82, 'h808, 1, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1, 1));

    #12;
    chk("rst_valid", bus.cdb_valid, 0);
    chk("rst_pc", bus.cdb_pc, 0);
    chk("rst_data", bus.cdb_data, 0);
    chk("rst_jpc", bus.cdb_jpc, 0);
    chk("rst_src", bus.cdb_src, 0);
    chk("rst_alu_ready", bus.alu_ready, 1);
    chk("rst_slb_ready", bus.slb_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.alu_valid = vecs[i].av; bus.alu_pc = vecs[i].apc;
      bus.alu_data  = vecs[i].adata; bus.alu_jpc = vecs[i].ajpc;
      bus.slb_valid = vecs[i].sv; bus.slb_pc = vecs[i].spc; bus.slb_data = vecs[i].sdata;
      flush = vecs[i].fl;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), bus.cdb_valid, vecs[i].ev);
      chk($sformatf("v%0d_alu_ready", i), bus.alu_ready, vecs[i].ear);
      chk($sformatf("v%0d_slb_ready", i), bus.slb_ready, vecs[i].esr);
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_pc", i), bus.cdb_pc, vecs[i].epc);
        chk($sformatf("v%0d_data", i), bus.cdb_data, vecs[i].edata);
        chk($sformatf("v%0d_jpc", i), bus.cdb_jpc, vecs[i].ejpc);
        chk($sformatf("v%0d_src", i), bus.cdb_src, vecs[i].esrc);
      end
    end
    @(negedge clk);
    drive_idle();

    do_flush("sat");
    stream(10, 10, 1, 0, "sat");
    do_flush("full");
    stream(6, 3, 0, 1, "full");
    stream(20, 0, 0, 0, "wrap");

    // Reset mid-operation clears outputs and queues without a clock edge.
    @(negedge clk);
    bus.alu_valid = 1; bus.alu_pc = 'h900; bus.alu_data = 'h91; bus.alu_jpc = 'h904;
    @(negedge clk);
    bus.alu_pc = 'h904; bus.alu_data = 'h92; bus.alu_jpc = 'h908;
    bus.slb_valid = 1; bus.slb_pc = 'hA00; bus.slb_data = 'hA1;
    @(posedge clk); #1;
    chk("mid_valid_before", bus.cdb_valid, 1);
    drive_idle();
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", bus.cdb_valid, 0);
    chk("mid_rst_pc", bus.cdb_pc, 0);
    chk("mid_rst_alu_ready", bus.alu_ready, 1);
    chk("mid_rst_slb_ready", bus.slb_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_dropped", bus.cdb_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
